// File: rtl/ahb_lite_sdram_bridge.sv
// rtl/ahb_lite_sdram_bridge.sv - AHB-Lite slave that queues single-beat commands for an SDRAM controller
`timescale 1ns/1ps

module ahb_lite_sdram_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic                    HREADY,
  input  logic [1:0]              HTRANS,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic                    HREADYOUT,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic                    HRESP,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_write_o,
  output logic [ADDR_WIDTH-1:0]   cmd_addr_o,
  output logic [2:0]              cmd_size_o,
  output logic [DATA_WIDTH/8-1:0] cmd_be_o,
  output logic [DATA_WIDTH-1:0]   cmd_wdata_o,
  input  logic [DATA_WIDTH-1:0]   sdram_rdata_i,
  input  logic                    sdram_rdata_valid_i,
  input  logic                    sdram_error_i
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int AL = $clog2(BW);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam int EW = ADDR_WIDTH + 1 + 3 + BW + DATA_WIDTH;
  localparam logic [2:0]  MAX_SIZE = 3'(AL);
  localparam logic [PW:0] DEPTH_L  = FIFO_DEPTH[PW:0];
  localparam logic [TW:0] TMO_LIM  = RD_TIMEOUT[TW:0];

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RWAIT, S_RDATA, S_ERR1, S_ERR2} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic [BW-1:0]           be_q, be_d;
  logic                    pushed_q, pushed_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [TW:0]             tmo_inc;
  logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
  logic                    hresp_q, hresp_d;

  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]             count_q, count_d;
  logic                    full, empty, push, pop, completing, accept, legal;
  logic [EW-1:0]           entry_d;
  logic [2:0]              lo, mask;
  logic [BW-1:0]           be_dec;
  logic                    hready_out;

  assign full   = (count_q == DEPTH_L);
  assign empty  = (count_q == '0);
  assign pop    = !empty && cmd_ready_i;
  assign accept = HSEL && HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);

  // Byte lane i is enabled when it falls in the same HSIZE-sized chunk as the address.
  always_comb begin
    lo = '0;
    lo[AL-1:0] = HADDR[AL-1:0];
    case (HSIZE)
      3'd0:    mask = 3'b000;
      3'd1:    mask = 3'b001;
      3'd2:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    legal = (HSIZE <= MAX_SIZE) && ((lo & mask) == 3'd0);
    for (int i = 0; i < BW; i++) begin
      be_dec[i] = ((3'(i) ^ lo) >> HSIZE) == 3'd0;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    be_d       = be_q;
    pushed_d   = pushed_q;
    tmo_d      = tmo_q;
    hrdata_d   = hrdata_q;
    push       = 1'b0;
    entry_d    = '0;
    completing = 1'b0;
    tmo_inc    = {1'b0, tmo_q} + {{TW{1'b0}}, 1'b1};
    case (state_q)
      S_IDLE, S_RDATA, S_ERR2: completing = 1'b1;
      S_WDATA: begin
        if (!full) begin
          completing = 1'b1;
          push       = 1'b1;
          entry_d    = {addr_q, 1'b1, size_q, be_q, HWDATA};
        end
      end
      S_RWAIT: begin
        if (!pushed_q) begin
          if (!full) begin
            push     = 1'b1;
            entry_d  = {addr_q, 1'b0, size_q, be_q, {DATA_WIDTH{1'b0}}};
            pushed_d = 1'b1;
            tmo_d    = '0;
          end
        end else if (sdram_rdata_valid_i) begin
          if (sdram_error_i) begin
            state_d = S_ERR1;
          end else begin
            hrdata_d = sdram_rdata_i;
            state_d  = S_RDATA;
          end
        end else if (RD_TIMEOUT != 0) begin
          if (tmo_inc == TMO_LIM) state_d = S_ERR1;
          else                    tmo_d   = tmo_inc[TW-1:0];
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    if (completing) begin
      if (accept) begin
        addr_d   = HADDR;
        size_d   = HSIZE;
        be_d     = be_dec;
        pushed_d = 1'b0;
        state_d  = !legal ? S_ERR1 : (HWRITE ? S_WDATA : S_RWAIT);
      end else begin
        state_d = S_IDLE;
      end
    end
    hresp_d = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      size_q   <= '0;
      be_q     <= '0;
      pushed_q <= 1'b0;
      tmo_q    <= '0;
      hrdata_q <= '0;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      be_q     <= be_d;
      pushed_q <= pushed_d;
      tmo_q    <= tmo_d;
      hrdata_q <= hrdata_d;
      hresp_q  <= hresp_d;
    end
  end

  // Command FIFO; a full queue refuses pushes even when the head leaves in the same cycle.
  always_comb begin
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) mem_q[wptr_q] <= entry_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    case (state_q)
      S_WDATA:         hready_out = !full;
      S_RWAIT, S_ERR1: hready_out = 1'b0;
      default:         hready_out = 1'b1;
    endcase
    {cmd_addr_o, cmd_write_o, cmd_size_o, cmd_be_o, cmd_wdata_o} = empty ? '0 : mem_q[rptr_q];
  end

  assign cmd_valid_o = !empty;
  assign HREADYOUT   = hready_out;
  assign HRESP       = hresp_q;
  assign HRDATA      = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_sdram_bridge.sv
// tb/tb_ahb_lite_sdram_bridge.sv - directed vector bench for ahb_lite_sdram_bridge
`timescale 1ns/1ps

module tb_ahb_lite_sdram_bridge;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic        HREADY;
  logic [1:0]  HTRANS = 2'b00;
  logic [31:0] HADDR = '0;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [31:0] HWDATA = '0;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        cmd_valid_o;
  logic        cmd_ready_i = 1'b1;
  logic        cmd_write_o;
  logic [31:0] cmd_addr_o;
  logic [2:0]  cmd_size_o;
  logic [3:0]  cmd_be_o;
  logic [31:0] cmd_wdata_o;
  logic [31:0] sdram_rdata_i = '0;
  logic        sdram_rdata_valid_i = 1'b0;
  logic        sdram_error_i = 1'b0;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_lite_sdram_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .RD_TIMEOUT(8)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY), .HTRANS(HTRANS),
    .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_write_o(cmd_write_o),
    .cmd_addr_o(cmd_addr_o), .cmd_size_o(cmd_size_o), .cmd_be_o(cmd_be_o),
    .cmd_wdata_o(cmd_wdata_o), .sdram_rdata_i(sdram_rdata_i),
    .sdram_rdata_valid_i(sdram_rdata_valid_i), .sdram_error_i(sdram_error_i)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    int          dly;
    logic        rerr;
    logic [31:0] rdata;
    int          exp_waits;
    logic        exp_resp;
    logic        exp_cmd;
    logic [3:0]  exp_be;
    logic [31:0] exp_hrdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t log_q[$];
  cmd_t mon_c;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(negedge HCLK) begin
    if (HRESETn && cmd_valid_o && cmd_ready_i) begin
      mon_c.wr = cmd_write_o; mon_c.addr = cmd_addr_o; mon_c.size = cmd_size_o;
      mon_c.be = cmd_be_o; mon_c.wdata = cmd_wdata_o;
      log_q.push_back(mon_c);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_xfer(input vec_t v, output int waits, output logic resp, output logic lwr);
    bit done = 0;
    HSEL = 1; HTRANS = 2'b10; HADDR = v.addr; HWRITE = v.wr; HSIZE = v.size;
    step();
    HSEL = 0; HTRANS = 2'b00; HWDATA = v.wr ? v.wdata : 32'h0;
    waits = 0; resp = 0; lwr = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      sdram_rdata_valid_i = 0; sdram_error_i = 0; sdram_rdata_i = '0;
      if (HREADYOUT) begin
        done = 1;
        resp = HRESP;
      end else begin
        waits++;
        lwr = HRESP;
        if (!v.wr && v.dly == i) begin
          sdram_rdata_valid_i = 1; sdram_error_i = v.rerr; sdram_rdata_i = v.rdata;
        end
        step();
      end
    end
    sdram_rdata_valid_i = 0; sdram_error_i = 0;
    if (!done) chk("xfer_bound", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  vec_t        vecs[11];
  logic [2:0]  pat[3];
  int          waits, n0, stalls;
  logic        resp, lwr;
  bit          done;

  initial begin
    vecs[0]  = '{1'b1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 1'b0, 32'h0,        0,  1'b0, 1'b1, 4'hF, 32'h0};
    vecs[1]  = '{1'b1, 32'h102, 3'd1, 32'hABCD0000, 0, 1'b0, 32'h0,        0,  1'b0, 1'b1, 4'hC, 32'h0};
    vecs[2]  = '{1'b1, 32'h103, 3'd0, 32'h5A000000, 0, 1'b0, 32'h0,        0,  1'b0, 1'b1, 4'h8, 32'h0};
    vecs[3]  = '{1'b0, 32'h040, 3'd2, 32'h0,        3, 1'b0, 32'h12345678, 4,  1'b0, 1'b1, 4'hF, 32'h12345678};
    vecs[4]  = '{1'b0, 32'h046, 3'd1, 32'h0,        1, 1'b0, 32'h5555AAAA, 2,  1'b0, 1'b1, 4'hC, 32'h5555AAAA};
    vecs[5]  = '{1'b0, 32'h002, 3'd2, 32'h0,        1, 1'b0, 32'h11111111, 1,  1'b1, 1'b0, 4'h0, 32'h5555AAAA};
    vecs[6]  = '{1'b0, 32'h080, 3'd2, 32'h0,        2, 1'b1, 32'hFFFFFFFF, 4,  1'b1, 1'b1, 4'hF, 32'h5555AAAA};
    vecs[7]  = '{1'b1, 32'h001, 3'd1, 32'h1234,     0, 1'b0, 32'h0,        1,  1'b1, 1'b0, 4'h0, 32'h5555AAAA};
    vecs[8]  = '{1'b1, 32'h000, 3'd3, 32'h1,        0, 1'b0, 32'h0,        1,  1'b1, 1'b0, 4'h0, 32'h5555AAAA};
    vecs[9]  = '{1'b0, 32'h021, 3'd0, 32'h0,        1, 1'b0, 32'h0000BB00, 2,  1'b0, 1'b1, 4'h2, 32'h0000BB00};
    vecs[10] = '{1'b0, 32'h060, 3'd2, 32'h0,        0, 1'b0, 32'h77777777, 10, 1'b1, 1'b1, 4'hF, 32'h0000BB00};
    pat[0] = 3'b100; pat[1] = 3'b101; pat[2] = 3'b010;

    // Reset state
    repeat (3) step();
    chk("rst_hreadyout", HREADYOUT, 1);
    chk("rst_hresp", HRESP, 0);
    chk("rst_hrdata", HRDATA, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_cmd_fields", {cmd_write_o, cmd_addr_o, cmd_size_o, cmd_be_o, cmd_wdata_o}, 0);
    HRESETn = 1;
    step();

    // IDLE, BUSY and unselected transfers: zero-wait OKAY, nothing queued
    n0 = log_q.size();
    for (int i = 0; i < 3; i++) begin
      HSEL = pat[i][2]; HTRANS = pat[i][1:0]; HADDR = 32'h500; HWRITE = 1; HSIZE = 3'd2;
      step();
      HSEL = 0; HTRANS = 2'b00;
      chk("noxfer_hreadyout", HREADYOUT, 1);
      chk("noxfer_hresp", HRESP, 0);
      step(); step();
      chk("noxfer_cmd_valid", cmd_valid_o, 0);
    end
    chk("noxfer_cmd_count", log_q.size() - n0, 0);

    // Single-beat vectors
    for (int k = 0; k < 11; k++) begin
      n0 = log_q.size();
      ahb_xfer(vecs[k], waits, resp, lwr);
      chk($sformatf("v%0d_waits", k), waits, vecs[k].exp_waits);
      chk($sformatf("v%0d_hresp", k), resp, vecs[k].exp_resp);
      chk($sformatf("v%0d_err1_phase", k), lwr, vecs[k].exp_resp);
      chk($sformatf("v%0d_hrdata", k), HRDATA, vecs[k].exp_hrdata);
      repeat (3) step();
      chk($sformatf("v%0d_cmd_count", k), log_q.size() - n0, vecs[k].exp_cmd);
      chk($sformatf("v%0d_drained", k), cmd_valid_o, 0);
      if (vecs[k].exp_cmd && log_q.size() > n0) begin
        chk($sformatf("v%0d_cmd_write", k), log_q[n0].wr, vecs[k].wr);
        chk($sformatf("v%0d_cmd_addr", k), log_q[n0].addr, vecs[k].addr);
        chk($sformatf("v%0d_cmd_size", k), log_q[n0].size, vecs[k].size);
        chk($sformatf("v%0d_cmd_be", k), log_q[n0].be, vecs[k].exp_be);
        chk($sformatf("v%0d_cmd_wdata", k), log_q[n0].wdata, vecs[k].wr ? vecs[k].wdata : 32'h0);
      end
    end

    // Five back-to-back writes into a 4-deep FIFO with the controller stalled
    cmd_ready_i = 0;
    n0 = log_q.size();
    HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HSIZE = 3'd2; HADDR = 32'h200;
    step();
    for (int k = 1; k <= 5; k++) begin
      HWDATA = 32'hA0000000 + k - 1;
      if (k < 5) begin
        HSEL = 1; HTRANS = 2'b11; HADDR = 32'h200 + 4 * k;
      end else begin
        HSEL = 0; HTRANS = 2'b00;
      end
      stalls = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        cmd_ready_i = 0;
        if (HREADYOUT) begin
          done = 1;
        end else begin
          stalls++;
          cmd_ready_i = (stalls == 3);
          step();
        end
      end
      cmd_ready_i = 0;
      if (!done) chk("burst_bound", 0, 1);
      chk($sformatf("burst_beat%0d_stalls", k), stalls, (k == 5) ? 3 : 0);
      chk($sformatf("burst_beat%0d_hresp", k), HRESP, 0);
      step();
    end
    cmd_ready_i = 1;
    repeat (8) step();
    chk("burst_cmd_count", log_q.size() - n0, 5);
    if (log_q.size() >= n0 + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("burst_order_addr%0d", k), log_q[n0+k].addr, 32'h200 + 4 * k);
        chk($sformatf("burst_order_wdata%0d", k), log_q[n0+k].wdata, 32'hA0000000 + k);
      end
    end

    // Reset while a read is waiting with its command still queued
    cmd_ready_i = 0;
    n0 = log_q.size();
    HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = 32'h70; HSIZE = 3'd2;
    step();
    HSEL = 0; HTRANS = 2'b00;
    step();
    chk("rwait_hreadyout", HREADYOUT, 0);
    chk("rwait_cmd_valid", cmd_valid_o, 1);
    chk("rwait_cmd_addr", cmd_addr_o, 32'h70);
    HRESETn = 0;
    #1;
    chk("midrst_hreadyout", HREADYOUT, 1);
    chk("midrst_hresp", HRESP, 0);
    chk("midrst_cmd_valid", cmd_valid_o, 0);
    chk("midrst_hrdata", HRDATA, 0);
    step();
    HRESETn = 1;
    cmd_ready_i = 1;
    step();
    sdram_rdata_valid_i = 1; sdram_rdata_i = 32'h99;
    step();
    sdram_rdata_valid_i = 0;
    step();
    chk("postrst_hrdata", HRDATA, 0);
    chk("postrst_hreadyout", HREADYOUT, 1);
    chk("postrst_cmd_count", log_q.size() - n0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
